cam_capture_sequencer: RTL and testbench
========================================

# cam_capture_sequencer

Sequences camera pixel capture into the frame buffer, between the OV7670 pixel packer and the frame-buffer write port. It aligns capture to frame boundaries. It supports stopped, single-snapshot and continuous modes. It crops a programmable region of interest (ROI) and writes it as a compact, zero-based raster, which feeds the region-zoom display path.

## Interface
- H_ACT, 320, active pixels per line
- V_ACT, 240, active lines per frame
- AW, 17, frame-buffer address width
- DW, 12, pixel width (RGB444)

Ports. Reset is reset, asynchronous, active-high; clock is pclk.
- pclk  in  1  camera pixel clock
- reset  in  1  asynchronous active-high reset
- v_sync  in  1  camera vsync; high marks vertical blanking
- href  in  1  line-valid from the camera
- pix_valid  in  1  one-cycle strobe from the packer: pix_data holds a complete pixel
- pix_data  in  DW  packed pixel
- cmd_start  in  1  start pulse
- cmd_single  in  1  sampled with cmd_start; 1 = snapshot, 0 = continuous
- cmd_stop  in  1  abort pulse
- roi_x0  in  9  ROI left column
- roi_y0  in  8  ROI top line
- roi_w  in  9  ROI width
- roi_h  in  8  ROI height
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  AW  write address
- fb_data  out  DW  write data
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- cfg_err  out  1  one-cycle pulse when a start is rejected
- frame_cnt  out  8  completed frames since reset; wraps 255→0

## Operation
- States: IDLE, WAIT_SOF, CAPTURE.
- IDLE → WAIT_SOF on cmd_start when the ROI is valid.
  - Valid ROI: w≠0, h≠0, x0+w≤H_ACT, y0+h≤V_ACT.
  - Invalid ROI: cfg_err pulses and the state stays IDLE.
- cmd_start is ignored in WAIT_SOF and CAPTURE.
- WAIT_SOF → CAPTURE on the v_sync falling edge (start of frame).
  - A start issued mid-frame therefore waits for the next frame. No partial frame is ever written.
- At every start of frame the ROI inputs are latched into shadow registers. ROI changes take effect only at a frame boundary.
- In CAPTURE, internal counters track position:
  - x counts pix_valid strobes within a line.
  - x clears on the href falling edge.
  - y increments on the href falling edge if x≠0.
  - x and y clear at start of frame.
  - Strobes with x≥H_ACT, or lines with y≥V_ACT, are ignored.
- A pixel is written iff x0≤x<x0+w and y0≤y<y0+h.
  - fb_addr = row_base + (x−x0).
  - row_base clears at start of frame and adds w at each in-window line end. No multiplier is used.
  - fb_data is pix_data registered.
- Frame end is the v_sync rising edge while in CAPTURE. On frame end, frame_done pulses and frame_cnt increments.
  - Snapshot mode: go to IDLE.
  - Continuous mode: go to WAIT_SOF.
- cmd_stop in WAIT_SOF or CAPTURE: go to IDLE next cycle; fb_we is low from that cycle; no frame_done.
- cmd_stop in IDLE is ignored.
- cmd_stop and cmd_start in the same cycle: stop wins.
- Frame end coinciding with cmd_stop: stop wins and frame_done is suppressed.

## Timing
- Reset: all outputs 0, state IDLE, counters and shadows 0.
- v_sync and href are registered once for edge detection. An edge acts on the cycle after it appears on the pin.
- Write latency: fb_we, fb_addr and fb_data are valid one cycle after the qualifying pix_valid. Back-to-back strobes give back-to-back writes.
- frame_done is asserted in the cycle after the registered v_sync rise. busy drops in that same cycle in snapshot mode.
- fb_addr range is 0 … w·h−1, which always fits AW bits for a valid ROI.

## Test plan
- ROI (0,0,320,240), snapshot, 2 frames driven:
  - exactly 76800 writes, addresses 0…76799 in order;
  - one frame_done, frame_cnt=1, busy low afterward, no writes in frame 2.
- ROI (100,50,160,120), snapshot:
  - first write at input pixel (100,50) to addr 0;
  - pixel (259,50) → addr 159; pixel (100,51) → addr 160;
  - last write addr 19199; 19200 writes total.
- cmd_start asserted mid-frame (v_sync low, line 80):
  - zero writes until the next v_sync fall;
  - the following frame is captured in full.
- cmd_stop at line 60 of a full-frame capture:
  - fb_we low from the next cycle;
  - no frame_done; frame_cnt unchanged; busy=0.
- ROI x0=200, w=160: start → cfg_err pulse for 1 cycle, state stays IDLE, no writes.
- Continuous mode, 3 frames; roi_w changed from 320 to 64 during frame 2:
  - frame 2 still writes 320-wide;
  - frame 3 writes 64-wide;
  - frame_cnt=3 and 3 frame_done pulses.

Source files
------------

// File: rtl/cam_capture_sequencer_if.sv
// Camera-to-frame-buffer capture bus: sensor timing, host commands and ROI in, frame-buffer writes and status out.
interface cam_capture_sequencer_if #(
  parameter int AW = 17,
  parameter int DW = 12
);
  logic          v_sync;
  logic          href;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          cmd_start;
  logic          cmd_single;
  logic          cmd_stop;
  logic [8:0]    roi_x0;
  logic [7:0]    roi_y0;
  logic [8:0]    roi_w;
  logic [7:0]    roi_h;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
  logic [7:0]    frame_cnt;

  modport master (
    output v_sync, href, pix_valid, pix_data, cmd_start, cmd_single, cmd_stop,
           roi_x0, roi_y0, roi_w, roi_h,
    input  fb_we, fb_addr, fb_data, busy, frame_done, cfg_err, frame_cnt
  );

  modport slave (
    input  v_sync, href, pix_valid, pix_data, cmd_start, cmd_single, cmd_stop,
           roi_x0, roi_y0, roi_w, roi_h,
    output fb_we, fb_addr, fb_data, busy, frame_done, cfg_err, frame_cnt
  );
endinterface

// File: rtl/cam_capture_sequencer.sv
// Frame-aligned capture sequencer: crops the ROI out of the camera raster and writes it
// to the frame buffer as a dense zero-based raster, in snapshot or continuous mode.
module cam_capture_sequencer #(
  parameter int H_ACT = 320,
  parameter int V_ACT = 240,
  parameter int AW    = 17,
  parameter int DW    = 12
) (
  input  logic pclk,
  input  logic reset,
  cam_capture_sequencer_if.slave bus
);
  localparam logic [9:0] HL = 10'(H_ACT);
  localparam logic [8:0] VL = 9'(V_ACT);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;
  state_t r_state, w_next;

  logic          r_vs, r_vs_d, r_href, r_href_d;
  logic          w_vs_fall, w_vs_rise, w_href_fall;
  logic [8:0]    r_x0, r_w;
  logic [7:0]    r_y0, r_h;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic [AW-1:0] r_row_base;
  logic          r_single;
  logic [9:0]    w_xend_in, w_xend;
  logic [8:0]    w_yend_in, w_yend;
  logic          w_roi_ok, w_start, w_win_y, w_win, w_cap, w_done, w_err;
  logic          r_we, r_done, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [7:0]    r_cnt;

  assign w_vs_fall   = r_vs_d & ~r_vs;
  assign w_vs_rise   = r_vs & ~r_vs_d;
  assign w_href_fall = r_href_d & ~r_href;

  // Live ROI is checked at start; the shadowed ROI drives the crop window.
  assign w_xend_in = {1'b0, bus.roi_x0} + {1'b0, bus.roi_w};
  assign w_yend_in = {1'b0, bus.roi_y0} + {1'b0, bus.roi_h};
  assign w_roi_ok  = (bus.roi_w != '0) && (bus.roi_h != '0) &&
                     (w_xend_in <= HL) && (w_yend_in <= VL);
  assign w_start   = bus.cmd_start & ~bus.cmd_stop;

  assign w_xend  = {1'b0, r_x0} + {1'b0, r_w};
  assign w_yend  = {1'b0, r_y0} + {1'b0, r_h};
  assign w_win_y = (r_y >= {1'b0, r_y0}) && (r_y < w_yend);
  assign w_win   = w_win_y && (r_x >= {1'b0, r_x0}) && (r_x < w_xend);
  assign w_cap   = (r_state == CAPTURE) & bus.pix_valid & ~bus.cmd_stop &
                   (r_x < HL) & (r_y < VL);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_roi_ok) w_next = WAIT_SOF;
          else          w_err  = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (bus.cmd_stop)   w_next = IDLE;
        else if (w_vs_fall) w_next = CAPTURE;
      end
      CAPTURE: begin
        if (bus.cmd_stop) w_next = IDLE;
        else if (w_vs_rise) begin
          w_done = 1'b1;
          w_next = r_single ? IDLE : WAIT_SOF;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_single <= 1'b0;
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_vs     <= bus.v_sync;
      r_vs_d   <= r_vs;
      r_href   <= bus.href;
      r_href_d <= r_href;
      r_done   <= w_done;
      r_err    <= w_err;
      if (w_done) r_cnt <= r_cnt + 8'd1;
      if (r_state == IDLE && w_start && w_roi_ok) r_single <= bus.cmd_single;
    end
  end

  // Raster position and row base; row_base accumulates w per finished window line.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else if (w_vs_fall) begin
      r_x0       <= bus.roi_x0;
      r_y0       <= bus.roi_y0;
      r_w        <= bus.roi_w;
      r_h        <= bus.roi_h;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else if (r_state == CAPTURE) begin
      if (w_href_fall) begin
        r_x <= '0;
        if (r_x != '0 && r_y < VL) begin
          r_y <= r_y + 9'd1;
          if (w_win_y) r_row_base <= r_row_base + AW'(r_w);
        end
      end else if (bus.pix_valid && r_x < HL) begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_cap & w_win;
      if (w_cap & w_win) begin
        r_addr <= r_row_base + AW'(r_x - {1'b0, r_x0});
        r_data <= bus.pix_data;
      end
    end
  end

  assign bus.fb_we      = r_we;
  assign bus.fb_addr    = r_addr;
  assign bus.fb_data    = r_data;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = r_done;
  assign bus.cfg_err    = r_err;
  assign bus.frame_cnt  = r_cnt;
endmodule

// File: tb/tb_cam_capture_sequencer.sv
// Scoreboard bench for cam_capture_sequencer on a reduced 40x30 raster so multi-frame runs stay short.
module tb_cam_capture_sequencer;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int AW = 17;
  localparam int DW = 12;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  cam_capture_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_sequencer #(.H_ACT(H), .V_ACT(V), .AW(AW), .DW(DW)) dut (
    .pclk (pclk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0, n_bad = 0, n_wr = 0, n_done = 0;
  logic pv_prev = 1'b0;

  int start_line = -1, stop_line = -1, stop_px = 0, chg_line = -1, chg_w = 0;
  bit start_single = 1'b1;
  bit cap_on;

  // Monitor: every frame-buffer write must match the head of the expected queue
  // and must follow a pix_valid strobe by exactly one cycle.
  always @(negedge pclk) begin
    if (!reset) begin
      if (bus.frame_done) n_done++;
      if (bus.fb_we) begin
        n_wr++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write got addr=%0d data=%h", bus.fb_addr, bus.fb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.fb_addr !== mon_e.addr || bus.fb_data !== mon_e.data || !pv_prev) begin
            n_bad++;
            $display("FAIL write got addr=%0d data=%h pv_prev=%b want addr=%0d data=%h",
                     bus.fb_addr, bus.fb_data, pv_prev, mon_e.addr, mon_e.data);
          end
        end
      end
    end
    pv_prev = bus.pix_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int x, input int y);
    return DW'(f * 311 + y * 53 + x * 7);
  endfunction

  task automatic set_roi(input int x0, input int y0, input int w, input int h);
    bus.roi_x0 = 9'(x0);
    bus.roi_y0 = 8'(y0);
    bus.roi_w  = 9'(w);
    bus.roi_h  = 8'(h);
  endtask

  task automatic pulse_start(input bit single);
    cyc();
    bus.cmd_start  = 1'b1;
    bus.cmd_single = single;
    cyc();
    bus.cmd_start  = 1'b0;
  endtask

  task automatic pulse_stop();
    cyc();
    bus.cmd_stop = 1'b1;
    cyc();
    bus.cmd_stop = 1'b0;
  endtask

  // One full camera frame; cap says whether the bench expects this frame to be captured
  // with the given ROI. Expected address is the plain raster offset inside the ROI.
  task automatic drive_frame(input int f, input bit cap, input int x0, input int y0,
                             input int w, input int h);
    wr_t e;
    cap_on = cap;
    cyc();
    bus.v_sync = 1'b0;
    repeat (4) cyc();
    for (int y = 0; y < V; y++) begin
      if (y == start_line) pulse_start(start_single);
      if (y == chg_line) bus.roi_w = 9'(chg_w);
      for (int x = 0; x < H; x++) begin
        cyc();
        bus.href      = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix(f, x, y);
        if (y == stop_line && x == stop_px) begin
          bus.cmd_stop = 1'b1;
          cap_on = 1'b0;
        end else begin
          bus.cmd_stop = 1'b0;
        end
        if (cap_on && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
          e.addr = AW'((y - y0) * w + (x - x0));
          e.data = pix(f, x, y);
          exp_q.push_back(e);
        end
      end
      cyc();
      bus.pix_valid = 1'b0;
      bus.href      = 1'b0;
      bus.cmd_stop  = 1'b0;
      repeat (4) cyc();
    end
    bus.v_sync = 1'b1;
    repeat (8) cyc();
  endtask

  int w0, d0;

  initial begin
    bus.v_sync = 1'b1; bus.href = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.cmd_start = 1'b0; bus.cmd_single = 1'b0; bus.cmd_stop = 1'b0;
    set_roi(0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_fb_we", int'(bus.fb_we), 0);
    check("rst_fb_addr", int'(bus.fb_addr), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    check("rst_frame_cnt", int'(bus.frame_cnt), 0);
    reset = 1'b0;
    repeat (2) cyc();

    // Full-frame snapshot, then a frame that must not be written.
    set_roi(0, 0, 40, 30);
    w0 = n_wr; d0 = n_done;
    pulse_start(1'b1);
    check("full_busy_after_start", int'(bus.busy), 1);
    drive_frame(1, 1'b1, 0, 0, 40, 30);
    check("full_writes", n_wr - w0, 1200);
    check("full_done", n_done - d0, 1);
    check("full_cnt", int'(bus.frame_cnt), 1);
    check("full_busy_end", int'(bus.busy), 0);
    drive_frame(2, 1'b0, 0, 0, 40, 30);
    check("full_frame2_writes", n_wr - w0, 1200);
    check("full_frame2_done", n_done - d0, 1);
    check("full_q_empty", exp_q.size(), 0);

    // Cropped snapshot.
    set_roi(10, 5, 20, 15);
    w0 = n_wr;
    pulse_start(1'b1);
    drive_frame(3, 1'b1, 10, 5, 20, 15);
    check("roi_writes", n_wr - w0, 300);
    check("roi_cnt", int'(bus.frame_cnt), 2);
    check("roi_busy_end", int'(bus.busy), 0);
    check("roi_q_empty", exp_q.size(), 0);

    // Start mid-frame waits for the next start of frame.
    set_roi(0, 0, 40, 30);
    w0 = n_wr;
    start_line = 10; start_single = 1'b1;
    drive_frame(4, 1'b0, 0, 0, 40, 30);
    start_line = -1;
    check("mid_writes_first", n_wr - w0, 0);
    check("mid_busy_waiting", int'(bus.busy), 1);
    drive_frame(5, 1'b1, 0, 0, 40, 30);
    check("mid_writes_next", n_wr - w0, 1200);
    check("mid_cnt", int'(bus.frame_cnt), 3);
    check("mid_q_empty", exp_q.size(), 0);

    // Stop mid-line during capture: the strobe with stop is not written.
    w0 = n_wr; d0 = n_done;
    pulse_start(1'b1);
    stop_line = 8; stop_px = 5;
    drive_frame(6, 1'b1, 0, 0, 40, 30);
    stop_line = -1;
    check("stop_writes", n_wr - w0, 8 * 40 + 5);
    check("stop_done", n_done - d0, 0);
    check("stop_cnt", int'(bus.frame_cnt), 3);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_q_empty", exp_q.size(), 0);

    // Invalid ROIs are rejected with a single-cycle cfg_err.
    set_roi(200 / 8, 0, 160 / 8, 10);
    w0 = n_wr;
    pulse_start(1'b1);
    check("bad_x_cfg_err", int'(bus.cfg_err), 1);
    check("bad_x_busy", int'(bus.busy), 0);
    cyc();
    check("bad_x_cfg_err_drop", int'(bus.cfg_err), 0);
    drive_frame(7, 1'b0, 0, 0, 40, 30);
    check("bad_x_writes", n_wr - w0, 0);
    set_roi(0, 0, 0, 10);
    pulse_start(1'b1);
    check("bad_w0_cfg_err", int'(bus.cfg_err), 1);
    set_roi(0, 25, 40, 6);
    pulse_start(1'b1);
    check("bad_y_cfg_err", int'(bus.cfg_err), 1);

    // Start and stop together: stop wins.
    set_roi(0, 0, 40, 30);
    cyc();
    bus.cmd_start = 1'b1; bus.cmd_stop = 1'b1;
    cyc();
    bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0;
    check("startstop_busy", int'(bus.busy), 0);
    check("startstop_cfg_err", int'(bus.cfg_err), 0);

    // ROI touching the bottom-right corner exactly is valid.
    set_roi(30, 20, 10, 10);
    w0 = n_wr;
    pulse_start(1'b1);
    check("edge_cfg_err", int'(bus.cfg_err), 0);
    drive_frame(8, 1'b1, 30, 20, 10, 10);
    check("edge_writes", n_wr - w0, 100);
    check("edge_cnt", int'(bus.frame_cnt), 4);
    check("edge_q_empty", exp_q.size(), 0);

    // Continuous: width change mid-frame 2 only applies from frame 3.
    set_roi(0, 0, 40, 30);
    w0 = n_wr; d0 = n_done;
    pulse_start(1'b0);
    drive_frame(9, 1'b1, 0, 0, 40, 30);
    check("cont_busy_f1", int'(bus.busy), 1);
    chg_line = 10; chg_w = 8;
    drive_frame(10, 1'b1, 0, 0, 40, 30);
    chg_line = -1;
    check("cont_writes_f2", n_wr - w0, 2400);
    drive_frame(11, 1'b1, 0, 0, 8, 30);
    check("cont_writes_f3", n_wr - w0, 2400 + 240);
    check("cont_done", n_done - d0, 3);
    check("cont_cnt", int'(bus.frame_cnt), 7);
    check("cont_busy", int'(bus.busy), 1);
    pulse_stop();
    check("cont_stop_busy", int'(bus.busy), 0);
    check("cont_q_empty", exp_q.size(), 0);

    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
